// File: rtl/ped_crossing_ctrl_if.sv
// ped_crossing_ctrl_if: controller lamps/countdown and button in, pedestrian lamps, request and display out
interface ped_crossing_ctrl_if;
    logic       btn;
    logic       red;
    logic       yellow;
    logic       green;
    logic [7:0] clock;
    logic       pass_request;
    logic       req_pending;
    logic       walk;
    logic       dont_walk;
    logic       walk_flash;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       light_fault;
    modport master(
        output btn, red, yellow, green, clock,
        input  pass_request, req_pending, walk, dont_walk, walk_flash, bcd_tens, bcd_ones, light_fault
    );
    modport slave(
        input  btn, red, yellow, green, clock,
        output pass_request, req_pending, walk, dont_walk, walk_flash, bcd_tens, bcd_ones, light_fault
    );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: debounced pedestrian request, walk lamps, BCD countdown and illegal-lamp detection
module ped_crossing_ctrl #(
    parameter int DEBOUNCE_CNT = 4,
    parameter int FLASH_CNT    = 5
) (
    input logic               clk,
    input logic               rst,
    ped_crossing_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CNT - 1);
    typedef enum logic {IDLE, PEND} state_t;
    state_t        state, state_nx;
    logic          btn_m, btn_s, btn_db;
    logic [CW-1:0] db_cnt;
    logic          press, fault, walk_nx, dark;
    logic [1:0]    lamp_sum;
    logic [6:0]    v;
    logic [3:0]    tens_nx, ones_nx;
    assign lamp_sum = {1'b0, bus.red} + {1'b0, bus.yellow} + {1'b0, bus.green};
    assign fault    = bus.light_fault | (lamp_sum >= 2'd2);
    assign dark     = lamp_sum == 2'd0;
    assign press    = btn_s && !btn_db && db_cnt == DB_LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_m  <= 1'b0;
            btn_s  <= 1'b0;
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else begin
            btn_m <= bus.btn;
            btn_s <= btn_m;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // a press while red is dropped: walk is already on, nothing to request
    always_comb begin
        state_nx = fault ? IDLE :
                   (state == IDLE) ? ((press && !bus.red) ? PEND : IDLE) :
                   (bus.red ? IDLE : PEND);
        walk_nx  = bus.red && !fault;
        v        = (bus.clock > 8'd99) ? 7'd99 : bus.clock[6:0];
        tens_nx  = dark ? 4'hF : 4'(v / 7'd10);
        ones_nx  = dark ? 4'hF : 4'(v % 7'd10);
    end
    assign bus.req_pending = state == PEND;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.pass_request <= 1'b0;
            bus.walk         <= 1'b0;
            bus.dont_walk    <= 1'b1;
            bus.walk_flash   <= 1'b0;
            bus.bcd_tens     <= 4'hF;
            bus.bcd_ones     <= 4'hF;
            bus.light_fault  <= 1'b0;
        end else begin
            bus.pass_request <= state_nx == PEND && bus.green && !fault;
            bus.walk         <= walk_nx;
            bus.dont_walk    <= !walk_nx;
            bus.walk_flash   <= walk_nx && bus.clock <= 8'(FLASH_CNT);
            bus.bcd_tens     <= tens_nx;
            bus.bcd_ones     <= ones_nx;
            bus.light_fault  <= fault;
        end
    end
endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb_ped_crossing_ctrl: directed scenarios plus randomized traffic checked against a behavioural model
module tb_ped_crossing_ctrl;
    localparam int DB = 4;
    localparam int FL = 5;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    ped_crossing_ctrl_if pif();
    ped_crossing_ctrl #(.DEBOUNCE_CNT(DB), .FLASH_CNT(FL)) dut (.clk(clk), .rst(rst), .bus(pif));
    // model: raw button history, synchronized history, and the observable outputs
    bit         bq[$];
    bit         sq[$];
    bit         m_db, m_pend, m_fault, m_pass, m_walk, m_flash;
    logic [3:0] m_tens, m_ones;
    logic [13:0] got, expv;
    assign got  = {pif.pass_request, pif.req_pending, pif.walk, pif.dont_walk, pif.walk_flash,
                   pif.bcd_tens, pif.bcd_ones, pif.light_fault};
    assign expv = {m_pass, m_pend, m_walk, ~m_walk, m_flash, m_tens, m_ones, m_fault};
    function automatic void model_reset();
        bq.delete();
        sq.delete();
        {m_db, m_pend, m_fault, m_pass, m_walk, m_flash} = '0;
        m_tens = 4'hF;
        m_ones = 4'hF;
    endfunction
    function automatic void model_step();
        bit bs, flip, press;
        int lit, v;
        bs = (bq.size() >= 2) ? bq[bq.size()-2] : 1'b0;
        bq.push_back(pif.btn);
        if (bq.size() > 4) void'(bq.pop_front());
        sq.push_back(bs);
        if (sq.size() > DB) void'(sq.pop_front());
        flip = sq.size() == DB;
        foreach (sq[i]) if (sq[i] == m_db) flip = 0;
        press = 0;
        if (flip) begin
            m_db  = !m_db;
            press = m_db;
        end
        lit = int'(pif.red) + int'(pif.yellow) + int'(pif.green);
        if (lit >= 2) m_fault = 1;
        if (m_fault)     m_pend = 0;
        else if (m_pend) m_pend = !pif.red;
        else             m_pend = press && !pif.red;
        m_pass  = m_pend && pif.green && !m_fault;
        m_walk  = pif.red && !m_fault;
        m_flash = m_walk && int'(pif.clock) <= FL;
        v = (pif.clock > 99) ? 99 : int'(pif.clock);
        m_tens = (lit == 0) ? 4'hF : 4'(v / 10);
        m_ones = (lit == 0) ? 4'hF : 4'(v % 10);
    endfunction
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
    endtask
    task automatic set_lamps(input logic [2:0] l, input logic [7:0] c);
        {pif.red, pif.yellow, pif.green} = l;
        pif.clock = c;
    endtask
    task automatic test_reset();
        pif.btn = 1'b0;
        set_lamps(3'b000, 8'd0);
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        checks++;
        if (got !== 14'b0001011111111_0) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", got, 14'b0001011111111_0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (got !== 14'b0001011111111_0 || got !== expv) begin
                errors++;
                $display("FAIL idle_dark: got %b expected %b", got, expv);
            end
        end
    endtask
    task automatic test_press_green();
        set_lamps(3'b001, 8'd45);
        tick();
        tick();
        pif.btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (pif.req_pending !== (i >= 5) || pif.pass_request !== (i >= 5) || got !== expv) begin
                errors++;
                $display("FAIL press_latency edge e+%0d: got req=%b pass=%b vec=%b expected req=pass=%b vec=%b",
                         i, pif.req_pending, pif.pass_request, got, i >= 5, expv);
            end
        end
        pif.btn = 1'b0;
        set_lamps(3'b100, 8'd30);
        tick();
        checks++;
        if ({pif.req_pending, pif.pass_request, pif.walk, pif.dont_walk} !== 4'b0010 || got !== expv) begin
            errors++;
            $display("FAIL red_serves: got req/pass/walk/dw=%b expected 0010", {pif.req_pending, pif.pass_request, pif.walk, pif.dont_walk});
        end
        repeat (6) tick();
    endtask
    task automatic test_short_pulses();
        set_lamps(3'b001, 8'd60);
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 6; i++) begin
                pif.btn = i < 3;
                tick();
                checks++;
                if (pif.req_pending !== 1'b0 || got !== expv) begin
                    errors++;
                    $display("FAIL short_pulse %0d/%0d: got req=%b vec=%b expected req=0 vec=%b", n, i, pif.req_pending, got, expv);
                end
            end
        end
        pif.btn = 1'b0;
        repeat (6) tick();
    endtask
    task automatic test_red_walk();
        set_lamps(3'b100, 8'd7);
        pif.btn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (pif.req_pending !== 1'b0 || pif.walk !== 1'b1 || got !== expv) begin
                errors++;
                $display("FAIL press_during_red %0d: got req=%b walk=%b expected req=0 walk=1", i, pif.req_pending, pif.walk);
            end
        end
        pif.btn = 1'b0;
        for (int c = 7; c >= 0; c--) begin
            pif.clock = 8'(c);
            tick();
            checks++;
            if ({pif.walk, pif.walk_flash, pif.bcd_tens, pif.bcd_ones} !== {1'b1, c <= FL, 4'd0, 4'(c)} || got !== expv) begin
                errors++;
                $display("FAIL red_sweep clock=%0d: got walk=%b flash=%b digits=%h%h expected walk=1 flash=%b digits=0%0d",
                         c, pif.walk, pif.walk_flash, pif.bcd_tens, pif.bcd_ones, c <= FL, c);
            end
        end
    endtask
    task automatic test_yellow();
        set_lamps(3'b010, 8'd150);
        tick();
        checks++;
        if ({pif.bcd_tens, pif.bcd_ones} !== 8'h99 || got !== expv) begin
            errors++;
            $display("FAIL clamp_99: got %h%h expected 99", pif.bcd_tens, pif.bcd_ones);
        end
        pif.btn = 1'b1;
        repeat (8) tick();
        pif.btn = 1'b0;
        tick();
        checks++;
        if (pif.req_pending !== 1'b1 || pif.pass_request !== 1'b0 || got !== expv) begin
            errors++;
            $display("FAIL yellow_press: got req=%b pass=%b expected req=1 pass=0", pif.req_pending, pif.pass_request);
        end
        set_lamps(3'b001, 8'd40);
        tick();
        checks++;
        if (pif.pass_request !== 1'b1 || got !== expv) begin
            errors++;
            $display("FAIL green_after_yellow: got pass=%b expected 1", pif.pass_request);
        end
        set_lamps(3'b100, 8'd20);
        repeat (6) tick();
    endtask
    task automatic test_async_reset();
        set_lamps(3'b001, 8'd50);
        pif.btn = 1'b1;
        repeat (7) tick();
        pif.btn = 1'b0;
        checks++;
        if (pif.req_pending !== 1'b1 || got !== expv) begin
            errors++;
            $display("FAIL pend_before_reset: got req=%b expected 1", pif.req_pending);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (got !== 14'b0001011111111_0) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", got, 14'b0001011111111_0);
        end
        rst = 1'b0;
        repeat (8) tick();
        checks++;
        if (pif.req_pending !== 1'b0 || got !== expv) begin
            errors++;
            $display("FAIL request_discarded: got req=%b expected 0", pif.req_pending);
        end
    endtask
    task automatic test_fault();
        set_lamps(3'b001, 8'd50);
        pif.btn = 1'b1;
        repeat (7) tick();
        pif.btn = 1'b0;
        repeat (6) tick();
        set_lamps(3'b101, 8'd50);
        tick();
        checks++;
        if ({pif.light_fault, pif.pass_request, pif.req_pending, pif.walk, pif.dont_walk} !== 5'b10001 || got !== expv) begin
            errors++;
            $display("FAIL fault_set: got fault/pass/req/walk/dw=%b expected 10001",
                     {pif.light_fault, pif.pass_request, pif.req_pending, pif.walk, pif.dont_walk});
        end
        set_lamps(3'b100, 8'd3);
        pif.btn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) set_lamps(3'b001, 8'd3);
            tick();
            checks++;
            if ({pif.light_fault, pif.req_pending, pif.walk, pif.walk_flash, pif.pass_request} !== 5'b10000 || got !== expv) begin
                errors++;
                $display("FAIL fault_sticky %0d: got fault/req/walk/flash/pass=%b expected 10000",
                         i, {pif.light_fault, pif.req_pending, pif.walk, pif.walk_flash, pif.pass_request});
            end
        end
        checks++;
        if ({pif.bcd_tens, pif.bcd_ones} !== 8'h03) begin
            errors++;
            $display("FAIL fault_digits: got %h%h expected 03", pif.bcd_tens, pif.bcd_ones);
        end
        pif.btn = 1'b0;
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (pif.light_fault !== 1'b0 || got !== expv) begin
            errors++;
            $display("FAIL fault_cleared: got fault=%b expected 0", pif.light_fault);
        end
    endtask
    task automatic test_random();
        int hold = 1;
        int r;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1 rst = 1'b0;
            end
            hold--;
            if (hold == 0) begin
                pif.btn = ~pif.btn;
                hold = $urandom_range(1, 9);
            end
            r = $urandom_range(0, 99);
            if (r < 5) begin
                r = $urandom_range(0, 99);
                {pif.red, pif.yellow, pif.green} = (r < 4)  ? 3'($urandom_range(0, 7)) :
                                                   (r < 15) ? 3'b000 : 3'b001 << $urandom_range(0, 2);
            end
            r = $urandom_range(0, 99);
            if (r < 40) pif.clock = (pif.clock == 8'd0 || r < 4) ? 8'($urandom_range(0, 255)) : pif.clock - 8'd1;
            tick();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL random cycle %0d: got %b expected %b", n, got, expv);
            end
        end
    endtask
    initial begin
        test_reset();
        test_press_green();
        test_short_pulses();
        test_red_walk();
        test_yellow();
        test_async_reset();
        test_fault();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Pedestrian-side companion to the intersection light controller: consumes its red/yellow/green lamp outputs and 8-bit countdown, and produces the `pass_request` input that shortens the green phase. It debounces a raw push-button, latches a pending request until the road goes red, drives the walk/don't-walk lamps and flash warning, and converts the countdown to two BCD display digits. It also flags illegal lamp patterns.

## Interface
- `DEBOUNCE_CNT`, 4: consecutive synchronized samples of a new button level required before it is accepted (≥2).
- `FLASH_CNT`, 5: during red, `walk_flash` is high while countdown ≤ this value.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `btn` in 1: raw pedestrian button, asynchronous, high = pressed.
- `red`, `yellow`, `green` in 1 each: controller lamp outputs.
- `clock` in 8: controller countdown, unsigned.
- `pass_request` out 1: request to controller to shorten green.
- `req_pending` out 1: "wait" lamp, request latched and not yet served.
- `walk` out 1, `dont_walk` out 1: pedestrian lamps, always complementary.
- `walk_flash` out 1: walk period ending.
- `bcd_tens` out 4, `bcd_ones` out 4: countdown display digits.
- `light_fault` out 1: sticky illegal-lamp flag.

## Operation
- Button path: 2-flop synchronizer → `btn_s`. Debounce counter increments on each edge where `btn_s` ≠ debounced level `btn_db`, clears when equal. On the edge where it would reach `DEBOUNCE_CNT`, `btn_db` takes `btn_s` and the counter clears. A press event is that edge with `btn_s`=1.
- FSM, two states:
  - IDLE: press event with `red`=0 → PEND. A press event while `red`=1 is ignored, since walk is already on.
  - PEND: further presses are ignored. `red` sampled 1 → IDLE (request served).
- `req_pending` = (state == PEND).
- `pass_request` is registered: the next value is 1 iff next state is PEND, `green`=1, and no fault.
- It stays asserted through green even when `clock` ≤ 10; the controller ignores it there.
- Lamps are registered:
  - `walk` = `red` & !fault.
  - `dont_walk` = !`walk`.
  - `walk_flash` = `walk`-condition & (`clock` ≤ `FLASH_CNT`).
- Display is registered:
  - v = min(`clock`, 99); `bcd_tens` = v/10, `bcd_ones` = v%10.
  - If `red`=`yellow`=`green`=0 (dark), both digits = 4'hF (blank).
  - No leading-zero suppression.
- Fault: `light_fault` is set on any edge where two or more lamp inputs are high, and cleared only by `rst`. While the fault is set (including the setting edge):
  - state is forced to IDLE;
  - `pass_request`, `walk`, `walk_flash` = 0 and `dont_walk` = 1;
  - digits are still driven.
- All-dark lamps are legal (controller reset/start-up) and do not set a fault.

## Timing
- Reset values: `pass_request` 0, `req_pending` 0, `walk` 0, `dont_walk` 1, `walk_flash` 0, `bcd_tens`/`bcd_ones` 4'hF, `light_fault` 0. State is IDLE, synchronizer and `btn_db` are 0, debounce counter is 0.
- `rst` mid-request discards the request immediately (asynchronous).
- Button latency: with e as the first edge sampling `btn`=1 held stable, `req_pending` rises after edge e+1+`DEBOUNCE_CNT` (e+5 at default).
- Pulses shorter than `DEBOUNCE_CNT` samples, including glitches, are never accepted. Release is debounced identically.
- `pass_request` rises on the same edge as `req_pending` if `green`=1, otherwise on the first edge sampling `green`=1.
- `red` sampled 1 on edge r: `req_pending` and `pass_request` fall after r, and `walk` rises after r.
- Lamp and display outputs lag their inputs by exactly 1 cycle.
- Simultaneous events:
  - press event on the edge sampling `red`=1: ignored;
  - press event with fault detected: fault wins;
  - PEND with `red`=1 and a press event together: → IDLE.

## Test plan
- Reset then idle inputs (lamps dark, `btn`=0) → `dont_walk`=1, digits F/F, all other outputs 0.
- `green`=1, `clock`=45, `btn` high 10 cycles → `req_pending` and `pass_request` high after edge e+5; then `red`=1 → both fall one edge later and `walk`=1.
- `btn` pulses of 3 cycles repeated during green → `req_pending` never rises.
- `red`=1, `clock`=7, press → no request. With `FLASH_CNT`=5, sweeping `clock` 7→0 gives `walk`=1 throughout and `walk_flash`=1 from `clock`=5; digits read 0/7…0/0.
- `clock`=150 with `yellow`=1 → digits 9/9. Press during yellow → `pass_request` stays 0 until `green`=1, then rises 1 cycle later.
- During PEND with `green`=1, drive `red`=`green`=1 → `light_fault`=1 stuck, `pass_request` 0, `walk` 0, state IDLE. Only `rst` clears it.
